// File: rtl/scan_addr_gen_if.sv
// Control/status bundle between a scan controller (master) and scan_addr_gen (slave).
// The master supplies start/stop and the dwell/last sweep parameters; the slave
// returns the decoder address/enable and scan status.
interface scan_addr_gen_if #(
    parameter int unsigned DWELL_W = 8
) ();

    logic               start;
    logic               stop;
    logic [DWELL_W-1:0] dwell;
    logic [3:0]         last;
    logic [3:0]         a;
    logic               e;
    logic               busy;
    logic               wrap;

    modport master (
        output start, stop, dwell, last,
        input  a, e, busy, wrap
    );

    modport slave (
        input  start, stop, dwell, last,
        output a, e, busy, wrap
    );

endinterface

// File: rtl/scan_addr_gen.sv
// Sequential address generator for a 4-to-16 active-low decoder.
// Sweeps addresses 0..last, holding each for dwell+1 cycles with the enable low,
// so exactly one decoder output is active at a time.
// Optional feature macro: SCAN_BLANK_EN inserts a one-cycle blank (e=1) between
// addresses and moves the wrap pulse into the blank following address `last`.
module scan_addr_gen #(
    parameter int unsigned DWELL_W = 8
) (
    input logic           clk,
    input logic           reset,
    scan_addr_gen_if.slave bus
);

    localparam int unsigned AW = 4;

`ifdef SCAN_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic               e_q, e_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [AW-1:0]      last_q, last_d;
    logic [AW-1:0]      next_addr;

    // State and registered outputs; reset forces the decoder fully disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            e_q     <= 1'b1;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register in step.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        dwell_d   = dwell_q;
        last_d    = last_q;
        e_d       = 1'b1;
        busy_d    = 1'b0;
        wrap_d    = 1'b0;
        next_addr = (a_q == last_q) ? '0 : a_q + AW'(1);

        case (state_q)
            ST_IDLE: begin
                a_d = '0;
                if (bus.start && !bus.stop) begin
                    dwell_d = bus.dwell;
                    last_d  = bus.last;
                    cnt_d   = bus.dwell;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cnt_q == '0) begin
`ifdef SCAN_BLANK_EN
                    state_d = ST_BLANK;
`else
                    a_d     = next_addr;
                    cnt_d   = dwell_q;
`endif
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
`ifdef SCAN_BLANK_EN
            ST_BLANK: begin
                a_d     = next_addr;
                cnt_d   = dwell_q;
                state_d = ST_SCAN;
            end
`endif
            default: begin
                state_d = ST_IDLE;
                a_d     = '0;
            end
        endcase

        // Abort from any active state; the current dwell is abandoned.
        if (bus.stop && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            a_d     = '0;
        end

        e_d    = (state_d != ST_SCAN);
        busy_d = (state_d != ST_IDLE);
`ifdef SCAN_BLANK_EN
        wrap_d = (state_d == ST_BLANK) && (a_d == last_d);
`else
        wrap_d = (state_d == ST_SCAN) && (cnt_d == '0) && (a_d == last_d);
`endif
    end

    assign bus.a    = a_q;
    assign bus.e    = e_q;
    assign bus.busy = busy_q;
    assign bus.wrap = wrap_q;

endmodule
